// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS register-file constants and types
package mips_pkg;
  localparam int REG_COUNT = 32;
  typedef logic [4:0] reg_addr_t;
  typedef logic [31:0] word_t;
  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/nbit_decoder.sv
// nbit_decoder: enable-gated one-hot decode of an AW-bit address
module nbit_decoder #(
  parameter int AW = 5
) (
  input  logic              en,
  input  logic [AW-1:0]     addr,
  output logic [2**AW-1:0]  onehot
);
  always_comb begin
    onehot = '0;
    onehot[addr] = en;
  end
endmodule

// File: rtl/mips_reg_file.sv
// mips_reg_file: 32x32 MIPS register file, 2 async read ports, 1 sync write port, optional bypass
module mips_reg_file
  import mips_pkg::*;
#(
  parameter int N      = 32,
  parameter int DEPTH  = REG_COUNT,
  parameter int AW     = $clog2(DEPTH),
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [N-1:0]  wd,
  output logic          wr_ack
);
  logic [N-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] wen;
  logic             byp;
  nbit_decoder #(.AW(AW)) u_dec (
    .en    (we),
    .addr  (wa),
    .onehot(en)
  );
  // $zero never gets an enable, so an X on we with wa=0 cannot reach any register
  assign wen = en & ~DEPTH'(1);
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) regs[i] <= '0;
      else if (wen[i]) regs[i] <= wd;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wr_ack <= 1'b0;
    else wr_ack <= |wen;
  // bypass is suppressed during reset so reads stay 0 while rst_n is low
  assign byp = (BYPASS != 0) && rst_n && we;
  assign rd1 = (ra1 == AW'(REG_ZERO)) ? '0 : (byp && wa == ra1) ? wd : regs[ra1];
  assign rd2 = (ra2 == AW'(REG_ZERO)) ? '0 : (byp && wa == ra2) ? wd : regs[ra2];
endmodule

// File: tb/tb_mips_reg_file.sv
// tb_mips_reg_file: randomized and directed checks of mips_reg_file (BYPASS=1 and BYPASS=0) against an array model
module tb_mips_reg_file;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        wr_ack, ack_nb;
  logic [31:0] model [32];
  logic        ack_m = 1'b0;
  int checks = 0;
  int failures = 0;

  mips_reg_file #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .wr_ack(wr_ack)
  );
  mips_reg_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .we(we), .wa(wa), .wd(wd), .wr_ack(ack_nb)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && rst_n && we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n && we && wa != 5'd0) model[wa] = wd;
    ack_m = rst_n && we && (wa != 5'd0);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) model[i] = '0;
    ra1 = 5'd5; ra2 = 5'd31;
    #3;
    checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL reset_rd1 got=%h exp=0", rd1); end
    checks++; if (rd2 !== 32'd0) begin failures++; $display("FAIL reset_rd2 got=%h exp=0", rd2); end
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", wr_ack); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_readback();
    we = 1'b1; wa = 5'd8; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0; ra1 = 5'd8;
    #1;
    checks++; if (rd1 !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd1 got=%h exp=deadbeef", rd1); end
    checks++; if (rd1_nb !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd1_nb got=%h exp=deadbeef", rd1_nb); end
    checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL wr_ack_hi got=%b exp=1", wr_ack); end
    tick();
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_lo got=%b exp=0", wr_ack); end
  endtask

  task automatic test_zero();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL zero_byp_rd1 got=%h exp=0", rd1); end
    checks++; if (rd2 !== 32'd0) begin failures++; $display("FAIL zero_byp_rd2 got=%h exp=0", rd2); end
    tick();
    we = 1'b0;
    #1;
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL zero_ack got=%b exp=0", wr_ack); end
    checks++; if (rd1 !== 32'd0 || rd2 !== 32'd0) begin failures++; $display("FAIL zero_rd got=%h/%h exp=0/0", rd1, rd2); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd3; wd = 32'h12345678; ra1 = 5'd3; ra2 = 5'd3;
    #1;
    checks++; if (rd1 !== 32'h12345678) begin failures++; $display("FAIL byp_rd1 got=%h exp=12345678", rd1); end
    checks++; if (rd2 !== 32'h12345678) begin failures++; $display("FAIL byp_rd2 got=%h exp=12345678", rd2); end
    checks++; if (rd1_nb !== 32'd0) begin failures++; $display("FAIL nobyp_old got=%h exp=0", rd1_nb); end
    tick();
    we = 1'b0;
    #1;
    checks++; if (rd1_nb !== 32'h12345678) begin failures++; $display("FAIL nobyp_new got=%h exp=12345678", rd1_nb); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  adr [3] = '{5'd1, 5'd2, 5'd31};
    logic [31:0] dat [3] = '{32'd1, 32'd2, 32'h80000000};
    for (int k = 0; k < 3; k++) begin
      we = 1'b1; wa = adr[k]; wd = dat[k];
      tick();
      checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack%0d got=%b exp=1", k, wr_ack); end
    end
    we = 1'b0;
    tick();
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL b2b_ack_end got=%b exp=0", wr_ack); end
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      checks++; if (rd1 !== exp_rd(ra1, 1'b1)) begin failures++; $display("FAIL b2b_rd1 r%0d got=%h exp=%h", i, rd1, exp_rd(ra1, 1'b1)); end
      checks++; if (rd2 !== exp_rd(ra2, 1'b1)) begin failures++; $display("FAIL b2b_rd2 r%0d got=%h exp=%h", 31 - i, rd2, exp_rd(ra2, 1'b1)); end
    end
    checks++; if (model[1] !== 32'd1 || model[2] !== 32'd2 || model[31] !== 32'h80000000) begin failures++; $display("FAIL b2b_model got=%h/%h/%h exp=1/2/80000000", model[1], model[2], model[31]); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1)); wa = 5'($urandom); wd = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom);
      #1;
      checks++; if (rd1 !== exp_rd(ra1, 1'b1)) begin failures++; $display("FAIL rnd_rd1 a=%0d got=%h exp=%h", ra1, rd1, exp_rd(ra1, 1'b1)); end
      checks++; if (rd2 !== exp_rd(ra2, 1'b1)) begin failures++; $display("FAIL rnd_rd2 a=%0d got=%h exp=%h", ra2, rd2, exp_rd(ra2, 1'b1)); end
      checks++; if (rd1_nb !== exp_rd(ra1, 1'b0)) begin failures++; $display("FAIL rnd_rd1_nb a=%0d got=%h exp=%h", ra1, rd1_nb, exp_rd(ra1, 1'b0)); end
      checks++; if (rd2_nb !== exp_rd(ra2, 1'b0)) begin failures++; $display("FAIL rnd_rd2_nb a=%0d got=%h exp=%h", ra2, rd2_nb, exp_rd(ra2, 1'b0)); end
      tick();
      checks++; if (wr_ack !== ack_m) begin failures++; $display("FAIL rnd_ack got=%b exp=%b", wr_ack, ack_m); end
      checks++; if (ack_nb !== ack_m) begin failures++; $display("FAIL rnd_ack_nb got=%b exp=%b", ack_nb, ack_m); end
    end
    we = 1'b0;
  endtask

  task automatic test_reset_mid();
    we = 1'b1; wa = 5'd4; wd = 32'hA5A5A5A5;
    tick();
    wd = 32'h1; ra1 = 5'd4; ra2 = 5'd4;
    #1;
    checks++; if (rd2_nb !== 32'hA5A5A5A5) begin failures++; $display("FAIL mid_loaded got=%h exp=a5a5a5a5", rd2_nb); end
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL mid_rst_rd1 got=%h exp=0", rd1); end
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL mid_rst_ack got=%b exp=0", wr_ack); end
    #2;
    rst_n = 1'b1; we = 1'b0;
    #1;
    checks++; if (rd1 !== 32'd0 || rd1_nb !== 32'd0) begin failures++; $display("FAIL mid_after_rd got=%h/%h exp=0/0", rd1, rd1_nb); end
    tick();
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL mid_after_ack got=%b exp=0", wr_ack); end
    checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL mid_after_edge got=%h exp=0", rd1); end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_zero();
    test_bypass();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
